// File: rtl/uart_pattern_gen.sv
// UART test-pattern generator: walks a character range and feeds uart_tx through
// its tx_start/tx_data/tx_busy handshake in single, line or stream mode.
module uart_pattern_gen #(
  parameter int         INTERVAL_CYCLES = 25_000_000,
  parameter logic [7:0] FIRST_CHAR      = 8'h41,
  parameter logic [7:0] LAST_CHAR       = 8'h5A,
  parameter bit         APPEND_CRLF     = 1'b1,
  parameter int         CNT_WIDTH       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [1:0]           mode,
  input  logic                 tx_busy,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  output logic [CNT_WIDTH-1:0] char_count,
  output logic                 heartbeat,
  output logic                 missed
);

  localparam int            TW          = (INTERVAL_CYCLES > 2) ? $clog2(INTERVAL_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST  = TW'(INTERVAL_CYCLES - 1);
  localparam logic [1:0]    MODE_SINGLE = 2'b00;
  localparam logic [1:0]    MODE_LINE   = 2'b01;
  localparam logic [1:0]    MODE_STREAM = 2'b10;
  localparam logic [7:0]    CHAR_CR     = 8'h0D;
  localparam logic [7:0]    CHAR_LF     = 8'h0A;

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_GUARD, ST_WAIT} state_t;

  state_t                 state_reg, state_next;
  logic [TW-1:0]          timer_reg;
  logic [1:0]             mode_reg, mode_next;
  logic [7:0]             ptr_reg, ptr_next, ptr_adv;
  logic [7:0]             tx_data_reg, tx_data_next;
  logic [CNT_WIDTH-1:0]   char_count_reg;
  logic                   heartbeat_reg, missed_reg;
  logic                   tick, in_range, crlf_en, line_done;

  assign tick       = enable && (timer_reg == TIMER_LAST);
  assign in_range   = (ptr_reg >= FIRST_CHAR) && (ptr_reg <= LAST_CHAR);
  assign crlf_en    = APPEND_CRLF && (mode_reg != MODE_SINGLE);
  assign line_done  = APPEND_CRLF ? (tx_data_reg == CHAR_LF) : (tx_data_reg == LAST_CHAR);

  assign tx_data    = tx_data_reg;
  assign char_count = char_count_reg;
  assign heartbeat  = heartbeat_reg;
  assign missed     = missed_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      timer_reg <= '0;
    else if (!enable || tick)
      timer_reg <= '0;
    else
      timer_reg <= timer_reg + 1'b1;
  end

  // Successor of ptr; CR/LF sit outside the character range and are only reachable
  // when framing is active for the latched mode.
  always_comb begin
    ptr_adv = ptr_reg + 8'd1;
    if (ptr_reg == LAST_CHAR)
      ptr_adv = crlf_en ? CHAR_CR : FIRST_CHAR;
    else if (!in_range)
      ptr_adv = (ptr_reg == CHAR_CR && crlf_en) ? CHAR_LF : FIRST_CHAR;
  end

  always_comb begin
    state_next   = state_reg;
    mode_next    = mode_reg;
    ptr_next     = ptr_reg;
    tx_data_next = tx_data_reg;
    tx_start     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        case (mode)
          MODE_SINGLE: if (tick) begin
            state_next   = ST_START;
            mode_next    = mode;
            ptr_next     = in_range ? ptr_reg : FIRST_CHAR;
            tx_data_next = in_range ? ptr_reg : FIRST_CHAR;
          end
          MODE_LINE: if (tick) begin
            state_next   = ST_START;
            mode_next    = mode;
            ptr_next     = FIRST_CHAR;
            tx_data_next = FIRST_CHAR;
          end
          MODE_STREAM: if (enable) begin
            state_next   = ST_START;
            mode_next    = mode;
            tx_data_next = ptr_reg;
          end
          default: ;
        endcase
      end
      ST_START: begin
        if (!tx_busy) begin
          tx_start   = 1'b1;
          ptr_next   = ptr_adv;
          state_next = ST_GUARD;
        end
      end
      // uart_tx may not have raised tx_busy yet in the cycle after the pulse.
      ST_GUARD: state_next = ST_WAIT;
      ST_WAIT: begin
        if (!tx_busy) begin
          state_next = ST_IDLE;
          if ((mode_reg == MODE_LINE && !line_done && enable) ||
              (mode_reg == MODE_STREAM && enable)) begin
            state_next   = ST_START;
            tx_data_next = ptr_reg;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      mode_reg       <= MODE_SINGLE;
      ptr_reg        <= FIRST_CHAR;
      tx_data_reg    <= FIRST_CHAR;
      char_count_reg <= '0;
      heartbeat_reg  <= 1'b0;
      missed_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      mode_reg    <= mode_next;
      ptr_reg     <= ptr_next;
      tx_data_reg <= tx_data_next;
      if (tx_start)
        char_count_reg <= char_count_reg + 1'b1;
      if (tick)
        heartbeat_reg <= ~heartbeat_reg;
      // Line and stream runs outlast a tick by design, so only single mode flags drops.
      if (tick && state_reg != ST_IDLE && mode_reg == MODE_SINGLE)
        missed_reg <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_pattern_gen.sv
// Bench for uart_pattern_gen: fixed scenario table, hand-written corner sequences and
// randomized runs checked against an event-level model of the character schedule.
module tb_uart_pattern_gen;

  localparam int N = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic        tx_busy;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic [15:0] char_count;
  logic        heartbeat;
  logic        missed;

  uart_pattern_gen #(
    .INTERVAL_CYCLES(N),
    .FIRST_CHAR(8'h41),
    .LAST_CHAR(8'h43),
    .APPEND_CRLF(1'b1),
    .CNT_WIDTH(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .mode(mode),
    .tx_busy(tx_busy),
    .tx_start(tx_start),
    .tx_data(tx_data),
    .char_count(char_count),
    .heartbeat(heartbeat),
    .missed(missed)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // uart_tx stand-in: busy for busy_len cycles after each captured start pulse
  int   busy_len = 10;
  int   busy_cnt;
  logic busy_ext = 1'b0;
  always @(posedge clk or posedge rst) begin
    if (rst)                busy_cnt <= 0;
    else if (tx_start)      busy_cnt <= busy_len;
    else if (busy_cnt > 0)  busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = (busy_cnt != 0) || busy_ext;

  typedef struct {
    int         off;
    logic [7:0] ch;
  } ev_t;

  ev_t  log_q[$];
  ev_t  exp_q[$];
  ev_t  mon_ev;
  int   e_cyc = 0;
  int   width_err = 0;
  logic prev_start = 1'b0;

  always @(negedge clk) begin
    if (tx_start) begin
      mon_ev.off = cyc - e_cyc;
      mon_ev.ch  = tx_data;
      log_q.push_back(mon_ev);
    end
    if (tx_start && prev_start) width_err <= width_err + 1;
    prev_start <= tx_start;
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " tx_start"},   tx_start,   0);
    chk({tag, " tx_data"},    tx_data,    8'h41);
    chk({tag, " char_count"}, char_count, 0);
    chk({tag, " heartbeat"},  heartbeat,  0);
    chk({tag, " missed"},     missed,     0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    enable = 1'b0;
    busy_ext = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Reset, raise enable for run cycles, drop it and let the last character drain.
  task automatic run_trial(input logic [1:0] m, input int l, input int run,
                           output int base, output int werr0);
    do_reset();
    busy_len = l;
    mode = m;
    @(posedge clk); #1;
    base  = log_q.size();
    werr0 = width_err;
    e_cyc = cyc;
    enable = 1'b1;
    repeat (run) @(posedge clk);
    #1 enable = 1'b0;
    repeat (l + 20) @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] char_of(input logic [1:0] m, input int idx);
    if (m == 2'b00) return 8'h41 + 8'(idx % 3);
    case (idx % 5)
      3:       return 8'h0D;
      4:       return 8'h0A;
      default: return 8'h41 + 8'(idx % 5);
    endcase
  endfunction

  // Schedule from the rules: ticks at offset 99+100k while enabled; a start at s keeps
  // the generator busy until tx_busy is seen low at s+L+1, so it is free again at s+L+2.
  task automatic model(input logic [1:0] m, input int l, input int run, output bit exp_missed);
    int p, idle_from, s, d;
    bit done;
    exp_q.delete();
    exp_missed = 1'b0;
    p = 0;
    idle_from = 0;
    if (m == 2'b00 || m == 2'b01) begin
      for (int t = N - 1; t <= run - 1; t += N) begin
        if (t < idle_from) begin
          if (m == 2'b00) exp_missed = 1'b1;
        end else if (m == 2'b00) begin
          exp_q.push_back('{t + 1, char_of(m, p)});
          p++;
          idle_from = t + 1 + l + 2;
        end else begin
          s = t + 1;
          done = 1'b0;
          for (int j = 0; j < 5 && !done; j++) begin
            exp_q.push_back('{s, char_of(m, j)});
            d = s + l + 1;
            if (j == 4 || d > run - 1) begin
              idle_from = d + 1;
              done = 1'b1;
            end else begin
              s = d + 1;
            end
          end
        end
      end
    end else if (m == 2'b10) begin
      s = 1;
      done = 1'b0;
      while (!done && exp_q.size() < 1000) begin
        exp_q.push_back('{s, char_of(m, p)});
        p++;
        d = s + l + 1;
        if (d <= run - 1) s = d + 1;
        else done = 1'b1;
      end
    end
  endtask

  typedef struct {
    logic [1:0] mode;
    int         busy;
    int         run;
    int         exp_count;
    bit         exp_missed;
    logic [7:0] exp_last;
    int         exp_first;
    bit         exp_hb;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int base, werr0, nlog, bad;
    bit em;
    logic [1:0] rm;
    int rl, rr;

    //            mode   busy run  cnt mis last   first hb
    vecs[0] = '{2'b00, 10,  410, 4,  0, 8'h41, 100, 0};  // single: A,B,C,A a tick apart
    vecs[1] = '{2'b01, 10,  170, 5,  0, 8'h0A, 100, 1};  // one full line with CR/LF
    vecs[2] = '{2'b10, 10,  30,  3,  0, 8'h43, 1,   0};  // stream, enable dropped during C
    vecs[3] = '{2'b00, 150, 310, 2,  1, 8'h42, 100, 1};  // tick lost while busy
    vecs[4] = '{2'b01, 30,  200, 4,  0, 8'h0D, 100, 0};  // line cut short, tick in WAIT ignored
    vecs[5] = '{2'b10, 3,   100, 20, 0, 8'h0A, 1,   1};  // fast stream
    vecs[6] = '{2'b01, 10,  210, 6,  0, 8'h41, 100, 0};  // second line restarts at A

    // reset must act without a clock edge
    #1 rst = 1'b1;
    #1 chk_reset_vals("async reset at power-up");
    do_reset();
    chk_reset_vals("after reset release");

    foreach (vecs[i]) begin
      run_trial(vecs[i].mode, vecs[i].busy, vecs[i].run, base, werr0);
      nlog = log_q.size() - base;
      $display("vec %0d: mode=%0d busy=%0d run=%0d starts=%0d", i, vecs[i].mode, vecs[i].busy, vecs[i].run, nlog);
      chk($sformatf("vec%0d char_count", i), char_count, vecs[i].exp_count);
      chk($sformatf("vec%0d pulses", i), nlog, vecs[i].exp_count);
      chk($sformatf("vec%0d missed", i), missed, vecs[i].exp_missed);
      chk($sformatf("vec%0d last tx_data", i), tx_data, vecs[i].exp_last);
      chk($sformatf("vec%0d first offset", i), (nlog > 0) ? log_q[base].off : -1, vecs[i].exp_first);
      chk($sformatf("vec%0d heartbeat", i), heartbeat, vecs[i].exp_hb);
      chk($sformatf("vec%0d pulse width", i), width_err - werr0, 0);
    end

    // tx_busy held high externally across the tick: one pulse once it drops
    do_reset();
    busy_len = 10;
    mode = 2'b00;
    busy_ext = 1'b1;
    @(posedge clk); #1;
    base = log_q.size();
    e_cyc = cyc;
    enable = 1'b1;
    repeat (150) @(posedge clk);
    #1 busy_ext = 1'b0;
    repeat (10) @(posedge clk);
    #1 enable = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    nlog = log_q.size() - base;
    $display("held busy: starts=%0d", nlog);
    chk("held busy pulses", nlog, 1);
    chk("held busy offset", (nlog > 0) ? log_q[base].off : -1, 150);
    chk("held busy char", (nlog > 0) ? log_q[base].ch : 8'h00, 8'h41);
    chk("held busy missed", missed, 0);

    // stream stopped during B keeps ptr at C, which single mode then sends
    do_reset();
    busy_len = 10;
    mode = 2'b10;
    @(posedge clk); #1;
    base = log_q.size();
    e_cyc = cyc;
    enable = 1'b1;
    repeat (18) @(posedge clk);
    #1 enable = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    nlog = log_q.size() - base;
    $display("stream stop: starts=%0d", nlog);
    chk("stream stop pulses", nlog, 2);
    chk("stream stop tx_data", tx_data, 8'h42);
    mode = 2'b00;
    @(posedge clk); #1;
    base = log_q.size();
    e_cyc = cyc;
    enable = 1'b1;
    repeat (110) @(posedge clk);
    #1 enable = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    nlog = log_q.size() - base;
    $display("resume single: starts=%0d", nlog);
    chk("resume pulses", nlog, 1);
    chk("resume char", (nlog > 0) ? log_q[base].ch : 8'h00, 8'h43);

    // asynchronous reset in the WAIT state of the third character
    do_reset();
    busy_len = 10;
    mode = 2'b00;
    @(posedge clk); #1;
    e_cyc = cyc;
    enable = 1'b1;
    repeat (305) @(posedge clk);
    #1;
    chk("pre-reset char_count", char_count, 3);
    chk("pre-reset heartbeat", heartbeat, 1);
    @(negedge clk); #1 rst = 1'b1;
    #1 chk_reset_vals("mid-WAIT reset");
    @(posedge clk); #1 rst = 1'b0;
    base = log_q.size();
    e_cyc = cyc;
    repeat (105) @(posedge clk);
    #1 enable = 1'b0;
    nlog = log_q.size() - base;
    $display("after mid-WAIT reset: starts=%0d", nlog);
    chk("post-reset offset", (nlog > 0) ? log_q[base].off : -1, 100);
    chk("post-reset char", (nlog > 0) ? log_q[base].ch : 8'h00, 8'h41);
    repeat (20) @(posedge clk);

    // randomized runs against the schedule model
    for (int k = 0; k < 20; k++) begin
      rm = 2'($urandom_range(0, 3));
      rl = int'($urandom_range(1, 160));
      rr = int'($urandom_range(20, 450));
      run_trial(rm, rl, rr, base, werr0);
      model(rm, rl, rr, em);
      nlog = log_q.size() - base;
      bad = 0;
      if (nlog != exp_q.size()) bad++;
      for (int j = 0; j < nlog && j < exp_q.size(); j++)
        if (log_q[base + j].off != exp_q[j].off || log_q[base + j].ch !== exp_q[j].ch) bad++;
      $display("trial %0d: mode=%0d busy=%0d run=%0d starts=%0d expected=%0d", k, rm, rl, rr, nlog, exp_q.size());
      chk($sformatf("rnd%0d schedule", k), bad, 0);
      chk($sformatf("rnd%0d char_count", k), char_count, exp_q.size());
      chk($sformatf("rnd%0d missed", k), missed, em);
      chk($sformatf("rnd%0d heartbeat", k), heartbeat, (rr / N) % 2);
      chk($sformatf("rnd%0d pulse width", k), width_err - werr0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
